// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer: synchronised power-up/restart sequencer releasing NUM_CH reset domains in order.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int PULSE_CYCLES   = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sw_rst_req,
  input  logic              fault_in,
  output logic [NUM_CH-1:0] ch_rst_out,
  output logic              all_ready,
  output logic [1:0]        seq_state,
  output logic [7:0]        restart_count
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  logic [1:0]        rst_sync_q;
  logic              rst_sync;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
  logic              ready_q, ready_d;
  logic [7:0]        restart_q, restart_d;
  logic              restart_en;

  // Assertion is immediate; release takes two clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_sync = rst_sync_q[1];

  // Only sequences that had started releasing domains count as restarts.
  assign restart_en = (state_q == S_RELEASE) || (state_q == S_RUN);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ch_rst_d  = ch_rst_q;
    ready_d   = ready_q;
    restart_d = restart_q;

    if (fault_in || (sw_rst_req && (state_q != S_FAULT))) begin
      state_d  = fault_in ? S_FAULT : S_HOLD;
      cnt_d    = '0;
      idx_d    = '0;
      ch_rst_d = '1;
      ready_d  = 1'b0;
      if (restart_en && (restart_q != 8'hFF)) begin
        restart_d = restart_q + 8'd1;
      end
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == PULSE_LAST) begin
            state_d  = S_RELEASE;
            cnt_d    = '0;
            idx_d    = '0;
            ch_rst_d = ch_rst_q << 1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RELEASE: begin
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
            ready_d = 1'b1;
          end else if (cnt_q == STAGGER_LAST) begin
            cnt_d    = '0;
            idx_d    = idx_q + IDX_W'(1);
            // Shifting in zeros from the LSB keeps releases in ascending order.
            ch_rst_d = ch_rst_q << 1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          ready_d = 1'b1;
        end
        S_FAULT: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
        default: begin
          state_d = S_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      ch_rst_q  <= '1;
      ready_q   <= 1'b0;
      restart_q <= 8'd0;
    end else if (rst_sync) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      ch_rst_q  <= '1;
      ready_q   <= 1'b0;
      restart_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ch_rst_q  <= ch_rst_d;
      ready_q   <= ready_d;
      restart_q <= restart_d;
    end
  end

  assign ch_rst_out    = ch_rst_q;
  assign all_ready     = ready_q;
  assign seq_state     = state_q;
  assign restart_count = restart_q;

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised power-up and reset sequencer for the motor controller.
- Synchronises release of the board-level `rst`, then holds all downstream reset domains for a programmable pulse.
- Releases the domains one at a time (for example PWM, encoder, current loop, comms) with a programmable stagger.
- Re-runs the sequence on a software request or a fault. Replaces the fixed single-pulse power-up reset.

Parameters:
- NUM_CH, 4: number of reset domains (≥1).
- PULSE_CYCLES, 16: clocks all domains are held after sequence start (≥1).
- STAGGER_CYCLES, 8: clocks between successive domain releases (≥1).
- CNT_W, 8: width of the internal cycle counter. Must hold max(PULSE_CYCLES, STAGGER_CYCLES).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sw_rst_req  in  1  synchronous one-cycle software restart request.
- fault_in  in  1  synchronous fault level (overcurrent/driver fault), active-high.
- ch_rst_out  out  NUM_CH  per-domain reset, active-high, registered.
- all_ready  out  1  high when every domain is released.
- seq_state  out  2  current state: HOLD=0, RELEASE=1, RUN=2, FAULT=3.
- restart_count  out  8  number of sequence restarts, saturating.

Behaviour:
- Reset (rst=1, async):
  - ch_rst_out = all ones, all_ready=0, seq_state=HOLD.
  - Internal counters = 0, restart_count = 0.
- Reset synchroniser:
  - Assertion of `rst` is immediate.
  - Deassertion passes a 2-flop synchroniser: rst_sync falls at E2, where E1 is the first clk edge after `rst` falls.
  - While rst_sync=1 the block stays in its reset state.
- Sequence timing:
  - Let X be the edge at which HOLD is entered; for power-up, X=E2.
  - ch_rst_out[k] falls at edge X + PULSE_CYCLES + k*STAGGER_CYCLES, for k = 0..NUM_CH-1.
  - all_ready rises one edge after ch_rst_out[NUM_CH-1] falls.
  - Released channels stay low until a restart or `rst`.
- HOLD:
  - Counts PULSE_CYCLES edges, then moves to RELEASE, with channel 0 released on that same edge.
- RELEASE:
  - Releases channel idx+1 every STAGGER_CYCLES edges.
  - After channel NUM_CH-1 is released, moves to RUN on the next edge, together with all_ready=1.
  - NUM_CH=1: HOLD → RELEASE → RUN still applies; all_ready rises at X+PULSE_CYCLES+1.
- RUN: steady state; all_ready=1.
- Restart priority (fault_in > sw_rst_req), evaluated every edge:
  - fault_in=1 in any state → FAULT next edge: ch_rst_out = all ones, all_ready=0.
  - sw_rst_req=1 in RELEASE or RUN → HOLD next edge: counters cleared, ch_rst_out = all ones, all_ready=0.
  - sw_rst_req=1 in HOLD → HOLD counter cleared (sequence restarts from that edge); restart_count unchanged.
  - sw_rst_req in FAULT is ignored.
- FAULT:
  - Holds all channels in reset while fault_in=1.
  - At the first edge that samples fault_in=0, moves to HOLD; that edge is the new X.
- restart_count:
  - Increments by 1 on every transition from RELEASE or RUN into HOLD or FAULT.
  - Saturates at 255.
  - FAULT entered from HOLD does not increment it.
- Outputs:
  - All outputs are registered; no combinational path from inputs.
  - ch_rst_out bits fall strictly in ascending index order and never glitch.

Test Plan:
- Defaults, `rst` released → ch_rst_out deasserts at E18/E26/E34/E42 in the order 4'b1110, 1100, 1000, 0000; all_ready=1 at E43; seq_state=2.
- In RUN, pulse sw_rst_req sampled at edge S → ch_rst_out=4'b1111 after S; ch0 falls at S+16, ch3 at S+40; restart_count=1.
- fault_in asserted mid-RELEASE (after ch0, ch1 released) for 10 cycles → all channels reasserted next edge; seq_state=3 for the duration; full sequence restarts from the edge fault_in is sampled low; restart_count increments by 1.
- fault_in and sw_rst_req high on the same edge in RUN → FAULT wins; restart_count increments by exactly 1.
- `rst` asserted asynchronously mid-STAGGER → all outputs return to reset values immediately, without waiting for an edge; restart_count=0.
- NUM_CH=1, PULSE_CYCLES=1, STAGGER_CYCLES=1 → ch_rst_out falls at E3, all_ready at E4. Force 300 restarts → restart_count saturates at 255.
